// File: rtl/oam_dma_controller_if.sv
// Bus bundle for the OAM DMA engine: CPU snoop, mmu read port, OAM write port and DMA register.
// master = the DMA controller, slave = the surrounding top level / memory system.
interface oam_dma_controller_if;
  logic        iCpuWe;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic [7:0]  iMemData;
  logic [15:0] oDmaAddr;
  logic        oDmaReadRequest;
  logic        oBusy;
  logic        oOamWe;
  logic [7:0]  oOamAddr;
  logic [7:0]  oOamData;
  logic [7:0]  oDmaReg;

  modport master (
    input  iCpuWe, iCpuAddr, iCpuData, iMemData,
    output oDmaAddr, oDmaReadRequest, oBusy, oOamWe, oOamAddr, oOamData, oDmaReg
  );

  modport slave (
    output iCpuWe, iCpuAddr, iCpuData, iMemData,
    input  oDmaAddr, oDmaReadRequest, oBusy, oOamWe, oOamAddr, oOamData, oDmaReg
  );
endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA engine: a CPU write to 0xFF46 copies 160 bytes from {page,00..9F} into OAM.
// Optional macro OAM_DMA_ECHO_FOLD_EN folds source pages E0-FF down onto C0-DF.
module oam_dma_controller #(
  parameter int OAM_BYTES     = 160,
  parameter int READ_LATENCY  = 1,
  parameter int STARTUP_DELAY = 2
) (
  input  logic                 iClock,
  input  logic                 iReset,
  oam_dma_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX   = 8'(OAM_BYTES - 1);
  localparam logic [7:0] DELAY_LAST = 8'(STARTUP_DELAY - 1);
  localparam logic [7:0] LAT_LAST   = 8'(READ_LATENCY);

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] delay_q, delay_d;
  logic [7:0] lat_q, lat_d;
  logic [7:0] data_q, data_d;
  logic [7:0] dma_reg_q, dma_reg_d;
  logic       trig;
  logic [7:0] page;

  assign trig = bus.iCpuWe && (bus.iCpuAddr == 16'hFF46);

`ifdef OAM_DMA_ECHO_FOLD_EN
  assign page = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;
`else
  assign page = src_q;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q   <= IDLE;
      src_q     <= 8'h00;
      idx_q     <= 8'h00;
      delay_q   <= 8'h00;
      lat_q     <= 8'h00;
      data_q    <= 8'h00;
      dma_reg_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      idx_q     <= idx_d;
      delay_q   <= delay_d;
      lat_q     <= lat_d;
      data_q    <= data_d;
      dma_reg_q <= dma_reg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    idx_d     = idx_q;
    delay_d   = delay_q;
    lat_d     = lat_q;
    data_d    = data_q;
    dma_reg_d = dma_reg_q;

    case (state_q)
      IDLE: ;
      START: begin
        if (delay_q == DELAY_LAST) begin
          state_d = READ;
          lat_d   = 8'h00;
        end else begin
          delay_d = delay_q + 8'h01;
        end
      end
      READ: begin
        if (lat_q == LAT_LAST) begin
          data_d  = bus.iMemData;
          state_d = WRITE;
        end else begin
          lat_d = lat_q + 8'h01;
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'h01;
          lat_d   = 8'h00;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A page write always wins, even over the final WRITE, so the transfer restarts.
    if (trig) begin
      dma_reg_d = bus.iCpuData;
      src_d     = bus.iCpuData;
      idx_d     = 8'h00;
      delay_d   = 8'h00;
      state_d   = START;
    end
  end

  always_comb begin
    bus.oBusy           = (state_q != IDLE);
    bus.oDmaReadRequest = 1'b0;
    bus.oDmaAddr        = 16'h0000;
    bus.oOamWe          = 1'b0;
    bus.oOamAddr        = 8'h00;
    bus.oOamData        = 8'h00;
    bus.oDmaReg         = dma_reg_q;
    if (state_q == READ) begin
      bus.oDmaReadRequest = 1'b1;
      bus.oDmaAddr        = {page, idx_q};
    end
    if (state_q == WRITE) begin
      bus.oOamWe   = 1'b1;
      bus.oOamAddr = idx_q;
      bus.oOamData = data_q;
    end
  end

endmodule
